// File: rtl/fpga2_receiver.sv
// Receive-side link controller: frame word-count check with
// speculative writes into a circular buffer, commit or rollback.
module fpga2_receiver #(
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 10,
    parameter int DEPTH      = 512,
    parameter int ACK_CYCLES = 3,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid_in,
    input  logic              send_done_in,
    input  logic [CNT_W-1:0]  expected_count,
    output logic              rdy_out,
    output logic              ack_out,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rx_empty,
    output logic [CNT_W:0]    rx_level,
    output logic              rx_done,
    output logic              rx_error,
    output logic              underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int HW = (ACK_CYCLES > 2) ? $clog2(ACK_CYCLES) + 1 : 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RECEIVE,
        S_CHECK,
        S_ACK,
        S_WAIT_REL,
        S_NACK
    } state_t;

    state_t state, state_n;

    logic              req_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              sd_q;
    logic              sd_prev;
    logic              sd_edge;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     commit_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     level_w;
    logic              full;

    logic [CNT_W-1:0]  exp_q;
    logic [CNT_W-1:0]  word_cnt;
    logic              ovf;
    logic [TW-1:0]     timer;
    logic [HW-1:0]     hold_cnt;

    logic arm;
    logic cnt_word;
    logic wr_word;
    logic do_commit;
    logic do_rollback;
    logic set_done;
    logic set_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sd_q    <= 1'b0;
            sd_prev <= 1'b0;
        end else begin
            req_q   <= req_in;
            data_q  <= data_in;
            valid_q <= data_valid_in;
            sd_q    <= send_done_in;
            sd_prev <= sd_q;
        end
    end

    assign sd_edge  = sd_q & ~sd_prev;
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rx_empty = (rd_ptr == commit_ptr);
    assign level_w  = commit_ptr - rd_ptr;
    assign rx_level = (CNT_W+1)'(level_w);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n     = state;
        rdy_out     = 1'b0;
        ack_out     = 1'b0;
        arm         = 1'b0;
        cnt_word    = 1'b0;
        wr_word     = 1'b0;
        do_commit   = 1'b0;
        do_rollback = 1'b0;
        set_done    = 1'b0;
        set_err     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req_q) state_n = S_ARMED;
            end
            S_ARMED: begin
                arm     = 1'b1;
                state_n = S_RECEIVE;
            end
            S_RECEIVE: begin
                rdy_out = 1'b1;
                if (valid_q) begin
                    cnt_word = 1'b1;
                    wr_word  = ~full;
                end
                // End-of-frame wins over release/timeout seen the same cycle
                if (sd_edge) begin
                    state_n = S_CHECK;
                end else if (!req_q ||
                             (!valid_q && timer == TW'(TIMEOUT))) begin
                    state_n     = S_NACK;
                    do_rollback = 1'b1;
                    set_err     = 1'b1;
                end
            end
            S_CHECK: begin
                rdy_out = 1'b1;
                if (word_cnt == exp_q && !ovf) begin
                    state_n   = S_ACK;
                    do_commit = 1'b1;
                    set_done  = 1'b1;
                end else begin
                    state_n     = S_NACK;
                    do_rollback = 1'b1;
                    set_err     = 1'b1;
                end
            end
            S_ACK: begin
                rdy_out = 1'b1;
                ack_out = 1'b1;
                if (hold_cnt == HW'(ACK_CYCLES - 1)) state_n = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (!req_q) state_n = S_IDLE;
            end
            S_NACK: begin
                if (hold_cnt == HW'(1)) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_word) mem[wr_ptr[AW-1:0]] <= data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            exp_q      <= '0;
            word_cnt   <= '0;
            ovf        <= 1'b0;
            timer      <= '0;
            hold_cnt   <= '0;
            rx_done    <= 1'b0;
            rx_error   <= 1'b0;
            underflow  <= 1'b0;
            rd_data    <= '0;
        end else begin
            rx_done  <= set_done;
            rx_error <= set_err;
            hold_cnt <= (state_n != state) ? '0 : hold_cnt + 1'b1;
            if (arm) begin
                exp_q    <= expected_count;
                word_cnt <= '0;
                ovf      <= 1'b0;
                wr_ptr   <= commit_ptr;
                timer    <= '0;
            end
            if (state == S_RECEIVE) begin
                if (valid_q || sd_edge) timer <= '0;
                else                    timer <= timer + 1'b1;
            end
            if (cnt_word && word_cnt != '1) word_cnt <= word_cnt + 1'b1;
            if (cnt_word && full)           ovf <= 1'b1;
            if (wr_word)                    wr_ptr <= wr_ptr + 1'b1;
            if (do_commit)                  commit_ptr <= wr_ptr;
            if (do_rollback)                wr_ptr <= commit_ptr;
            underflow <= rd_en & rx_empty;
            if (rd_en && !rx_empty) begin
                rd_data <= mem[rd_ptr[AW-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpga2_receiver.sv
// Bench for fpga2_receiver: queue-level buffer model checked every
// cycle, plus directed frames with hand-computed expectations.
module tb_fpga2_receiver;

    localparam int DW    = 32;
    localparam int CW    = 10;
    localparam int DEPTH = 8;
    localparam int ACKC  = 3;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          data_valid_in = 1'b0;
    logic          send_done_in = 1'b0;
    logic [CW-1:0] expected_count = '0;
    logic          rd_en = 1'b0;
    logic          rdy_out;
    logic          ack_out;
    logic [DW-1:0] rd_data;
    logic          rx_empty;
    logic [CW:0]   rx_level;
    logic          rx_done;
    logic          rx_error;
    logic          underflow;

    fpga2_receiver #(
        .DATA_W(DW), .CNT_W(CW), .DEPTH(DEPTH),
        .ACK_CYCLES(ACKC), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_in(req_in), .data_in(data_in),
        .data_valid_in(data_valid_in),
        .send_done_in(send_done_in),
        .expected_count(expected_count),
        .rdy_out(rdy_out), .ack_out(ack_out),
        .rd_en(rd_en), .rd_data(rd_data),
        .rx_empty(rx_empty), .rx_level(rx_level),
        .rx_done(rx_done), .rx_error(rx_error),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Model: committed words, words of the frame in flight, and expectations
    logic [DW-1:0] mq[$];
    logic [DW-1:0] fq[$];
    bit            m_active = 1'b0;
    int            m_cnt = 0;
    bit            m_ovf = 1'b0;
    int            m_exp = 0;
    int            m_eval_cyc = -1;
    int            m_abort_cyc = -1;
    bit            v_d = 1'b0;
    logic [DW-1:0] d_d = '0;
    logic [DW-1:0] m_rd_data = '0;
    bit            m_under = 1'b0;
    bit            m_done = 1'b0;
    bit            m_err = 1'b0;
    int            m_ack_left = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h",
                     nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_under = 1'b0;
        if (m_ack_left > 0) m_ack_left--;
        if (rst) begin
            mq.delete();
            fq.delete();
            m_active    = 1'b0;
            m_rd_data   = '0;
            m_ack_left  = 0;
            v_d         = 1'b0;
            d_d         = '0;
            m_eval_cyc  = -1;
            m_abort_cyc = -1;
        end else begin
            if (m_active && v_d) begin
                m_cnt++;
                if (mq.size() + fq.size() < DEPTH) fq.push_back(d_d);
                else m_ovf = 1'b1;
            end
            if (rd_en) begin
                if (mq.size() > 0) m_rd_data = mq.pop_front();
                else m_under = 1'b1;
            end
            if (cyc == m_eval_cyc) begin
                if (m_cnt == m_exp && !m_ovf) begin
                    foreach (fq[i]) mq.push_back(fq[i]);
                    m_done     = 1'b1;
                    m_ack_left = ACKC;
                end else begin
                    m_err = 1'b1;
                end
                fq.delete();
                m_active = 1'b0;
            end
            if (cyc == m_abort_cyc) begin
                m_err = 1'b1;
                fq.delete();
                m_active = 1'b0;
            end
            v_d = data_valid_in;
            d_d = data_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("rx_level", 64'(rx_level), 64'(mq.size()));
            check("rx_empty", 64'(rx_empty), 64'(mq.size() == 0));
            check("underflow", 64'(underflow), 64'(m_under));
            check("rd_data", 64'(rd_data), 64'(m_rd_data));
            check("rx_done", 64'(rx_done), 64'(m_done));
            check("rx_error", 64'(rx_error), 64'(m_err));
            check("ack_out", 64'(ack_out), 64'(m_ack_left > 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (rdy_out !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) begin
            tests++;
            fails++;
            $display("FAIL wait_rdy: rdy_out=%b after %0d cycles, want 1",
                     rdy_out, n);
        end
    endtask

    task automatic start_frame(input int ex);
        expected_count = CW'(ex);
        req_in = 1'b1;
        wait_rdy();
        fq.delete();
        m_cnt    = 0;
        m_ovf    = 1'b0;
        m_exp    = ex;
        m_active = 1'b1;
    endtask

    task automatic frame(input int n, input int ex,
                         input logic [DW-1:0] base, input bit with_sd);
        start_frame(ex);
        for (int i = 0; i < n; i++) begin
            data_valid_in = 1'b1;
            data_in = base + DW'(i);
            if (with_sd && i == n - 1) begin
                send_done_in = 1'b1;
                m_eval_cyc = cyc + 3;
            end
            tick();
        end
        data_valid_in = 1'b0;
        if (!(with_sd && n > 0)) begin
            send_done_in = 1'b1;
            m_eval_cyc = cyc + 3;
            tick();
        end
        tick();
        tick();
        send_done_in = 1'b0;
        while (cyc < m_eval_cyc) tick();
    endtask

    task automatic release_req();
        req_in = 1'b0;
        repeat (8) tick();
    endtask

    task automatic pop_check(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            tick();
            check("pop_word", 64'(rd_data), 64'(base + DW'(i)));
        end
        rd_en = 1'b0;
        tick();
    endtask

    logic [DW-1:0] conc_exp[12] = '{
        32'h10, 32'h11, 32'h12, 32'h13,
        32'h20, 32'h21, 32'h22, 32'h23,
        32'h24, 32'h25, 32'h26, 32'h27
    };
    bit frame_done = 1'b0;

    initial begin
        int last_c;
        int nrd;
        int guard;
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_rdy", 64'(rdy_out), 64'd0);
        check("reset_empty", 64'(rx_empty), 64'd1);
        check("reset_level", 64'(rx_level), 64'd0);
        check("reset_rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;
        tick();

        frame(4, 4, 32'hA0, 1'b0);
        check("good_level", 64'(rx_level), 64'd4);
        check("good_ack", 64'(ack_out), 64'd1);
        check("good_done", 64'(rx_done), 64'd1);
        release_req();
        pop_check(4, 32'hA0);
        check("good_drained", 64'(rx_empty), 64'd1);

        frame(4, 5, 32'hB0, 1'b0);
        check("short_err", 64'(rx_error), 64'd1);
        check("short_noack", 64'(ack_out), 64'd0);
        check("short_rdy0", 64'(rdy_out), 64'd0);
        tick();
        check("short_rdy0b", 64'(rdy_out), 64'd0);
        frame(5, 5, 32'hC0, 1'b0);
        check("resend_level", 64'(rx_level), 64'd5);
        check("resend_ack", 64'(ack_out), 64'd1);
        release_req();
        pop_check(5, 32'hC0);

        frame(6, 6, 32'hD0, 1'b0);
        release_req();
        frame(4, 4, 32'hE0, 1'b0);
        check("ovf_err", 64'(rx_error), 64'd1);
        check("ovf_level", 64'(rx_level), 64'd6);
        release_req();

        start_frame(4);
        for (int i = 0; i < 3; i++) begin
            data_valid_in = 1'b1;
            data_in = 32'h50 + DW'(i);
            tick();
        end
        rst = 1'b1;
        req_in = 1'b0;
        data_valid_in = 1'b0;
        tick();
        check("rstmid_rdy", 64'(rdy_out), 64'd0);
        check("rstmid_empty", 64'(rx_empty), 64'd1);
        check("rstmid_level", 64'(rx_level), 64'd0);
        rst = 1'b0;
        tick();
        frame(4, 4, 32'hF0, 1'b1);
        check("post_rst_level", 64'(rx_level), 64'd4);
        release_req();

        start_frame(4);
        for (int i = 0; i < 2; i++) begin
            data_valid_in = 1'b1;
            data_in = 32'h70 + DW'(i);
            last_c = cyc;
            tick();
        end
        data_valid_in = 1'b0;
        m_abort_cyc = last_c + 19;
        while (cyc < m_abort_cyc) tick();
        check("tmo_err", 64'(rx_error), 64'd1);
        check("tmo_rdy", 64'(rdy_out), 64'd0);
        check("tmo_level", 64'(rx_level), 64'd4);
        req_in = 1'b0;
        repeat (6) tick();
        pop_check(4, 32'hF0);

        frame(0, 0, 32'h0, 1'b0);
        check("zero_ack", 64'(ack_out), 64'd1);
        check("zero_done", 64'(rx_done), 64'd1);
        check("zero_level", 64'(rx_level), 64'd0);
        release_req();

        frame(4, 4, 32'h10, 1'b0);
        release_req();
        nrd = 0;
        fork
            begin
                frame(8, 8, 32'h20, 1'b0);
                release_req();
                frame_done = 1'b1;
            end
            begin
                guard = 0;
                while (!(frame_done && mq.size() == 0) && guard < 200) begin
                    rd_en = (mq.size() > 0);
                    tick();
                    if (rd_en) begin
                        if (nrd < 12)
                            check("conc_order", 64'(rd_data),
                                  64'(conc_exp[nrd]));
                        nrd++;
                    end
                    guard++;
                end
                rd_en = 1'b0;
            end
        join
        check("conc_count", 64'(nrd), 64'd12);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("conc_underflow", 64'(underflow), 64'd1);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
